text_console: RTL and testbench

Character-stream console controller that sits directly upstream of the VGA text-mode display stage. It accepts ASCII bytes over a valid/ready handshake, maintains a cursor, writes 16-bit character words into the 80×60 text VRAM, and performs clear-screen and one-line scroll by VRAM-to-VRAM copy. Its cursor output drives the display's hardware cursor input directly, in {row[5:0], col[6:0]} format.

---
 rtl/text_console.sv | 217 +++++++++++++++++++++
 tb/tb_text_console.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// text_console: character-stream console controller feeding the 80x60
// VGA text VRAM. Accepts ASCII bytes on a valid/ready handshake, keeps a
// cursor, writes {attr, 0, char[6:0]} words, and clears or scrolls the
// screen by streaming through VRAM one word per cycle.
//
// Optional feature: define CONSOLE_TAB_EN to make 0x09 advance the cursor
// to the next 8-column tab stop; otherwise 0x09 is consumed silently.
//
// Address formation (row<<6)+(row<<4)+col is specific to an 80-column
// screen, so the geometry is fixed rather than parameterised.
module text_console (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  output logic        vram_we,
  output logic [12:0] vram_wa,
  output logic [15:0] vram_wd,
  output logic [12:0] vram_ra,
  input  logic [15:0] vram_rd,
  output logic [12:0] cursor,
  output logic        busy
);

  localparam int          COLS       = 80;
  localparam int          ROWS       = 60;
  localparam logic [15:0] BLANK      = 16'h0020;
  localparam logic [12:0] LAST_ADDR  = 13'(COLS * ROWS - 1);   // 4799
  localparam logic [12:0] COPY_WORDS = 13'(COLS * (ROWS - 1)); // 4720
  localparam logic [12:0] COLS_A     = 13'(COLS);
  localparam logic [12:0] FILL_LAST  = 13'(COLS - 1);
  localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);

  typedef enum logic [1:0] {
    CLEAR       = 2'd0,
    IDLE        = 2'd1,
    SCROLL_COPY = 2'd2,
    SCROLL_FILL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [5:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic        we_q, we_d;
  logic [12:0] wa_q, wa_d;
  logic [15:0] wd_q, wd_d;
  logic [12:0] ra_q, ra_d;

  logic        row_inc;
  logic        is_print;
  logic [15:0] char_word;
  logic [12:0] cur_addr;

  // Linear VRAM address of the cursor: row*80 + col using shifts only.
  assign cur_addr  = ({7'd0, row_q} << 6) + ({7'd0, row_q} << 4) + {6'd0, col_q};
  assign is_print  = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign char_word = {in_attr, 1'b0, in_char[6:0]};

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign cursor   = {row_q, col_q};
  assign vram_we  = we_q;
  assign vram_wa  = wa_q;
  assign vram_wd  = wd_q;
  assign vram_ra  = ra_q;

  // State, cursor, counter and registered VRAM port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      ra_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      ra_q    <= ra_d;
    end
  end

  // Next-state, cursor movement and VRAM traffic for each state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    ra_d    = ra_q;
    row_inc = 1'b0;

    case (state_q)
      CLEAR: begin
        we_d = 1'b1;
        wa_d = cnt_q;
        wd_d = BLANK;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid here is an accept.
        if (in_valid) begin
          case (in_char)
            8'h0D: col_d = '0;
            8'h0A: row_inc = 1'b1;
            8'h08: begin
              if (col_q != 7'd0) begin
                col_d = col_q - 7'd1;
                we_d  = 1'b1;
                wa_d  = cur_addr - 13'd1;
                wd_d  = BLANK;
              end
            end
            8'h0C: begin
              state_d = CLEAR;
              cnt_d   = '0;
              row_d   = '0;
              col_d   = '0;
            end
`ifdef CONSOLE_TAB_EN
            8'h09: begin
              // Tab stops every 8 columns; the last stop wraps to a new line.
              if (col_q >= 7'(COLS - 8)) begin
                col_d   = '0;
                row_inc = 1'b1;
              end else begin
                col_d = {col_q[6:3], 3'b000} + 7'd8;
              end
            end
`endif
            default: begin
              if (is_print) begin
                we_d = 1'b1;
                wa_d = cur_addr;
                wd_d = char_word;
                if (col_q == LAST_COL) begin
                  col_d   = '0;
                  row_inc = 1'b1;
                end else begin
                  col_d = col_q + 7'd1;
                end
              end
            end
          endcase

          // Moving past the bottom row keeps the cursor there and scrolls;
          // the first source word (row 1, col 0) is addressed right away.
          if (row_inc) begin
            if (row_q == LAST_ROW) begin
              state_d = SCROLL_COPY;
              cnt_d   = '0;
              ra_d    = COLS_A;
            end else begin
              row_d = row_q + 6'd1;
            end
          end
        end
      end

      SCROLL_COPY: begin
        // cnt tracks the read in flight; the write lags it by one cycle to
        // match the one-cycle VRAM read latency, plus a final drain cycle.
        if (cnt_q != 13'd0) begin
          we_d = 1'b1;
          wa_d = cnt_q - 13'd1;
          wd_d = vram_rd;
        end
        if (cnt_q < COPY_WORDS - 13'd1) begin
          ra_d = cnt_q + COLS_A + 13'd1;
        end
        if (cnt_q == COPY_WORDS) begin
          cnt_d   = '0;
          state_d = SCROLL_FILL;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      SCROLL_FILL: begin
        we_d = 1'b1;
        wa_d = COPY_WORDS + cnt_q;
        wd_d = BLANK;
        if (cnt_q == FILL_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end

      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_text_console.sv
// Testbench for text_console: a VRAM model, a screen-level reference model
// that expands each accepted byte into the per-cycle output sequence it
// must produce, a per-cycle compare process, and directed plus random
// stimulus.
module tb_text_console;

  localparam logic [15:0] BLANK = 16'h0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        vram_we;
  logic [12:0] vram_wa;
  logic [15:0] vram_wd;
  logic [12:0] vram_ra;
  logic [15:0] vram_rd;
  logic [12:0] cursor;
  logic        busy;

  int total  = 0;
  int errors = 0;

  text_console dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_char  (in_char),
    .in_attr  (in_attr),
    .vram_we  (vram_we),
    .vram_wa  (vram_wa),
    .vram_wd  (vram_wd),
    .vram_ra  (vram_ra),
    .vram_rd  (vram_rd),
    .cursor   (cursor),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // VRAM: synchronous write, one-cycle registered read.
  logic [15:0] ram [0:8191];
  always @(posedge clk) begin
    if (vram_we) ram[vram_wa] <= vram_wd;
    vram_rd <= ram[vram_ra];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        busy;
    logic        we;
    logic [12:0] addr;
    logic [15:0] data;
  } ent_t;

  ent_t        sched[$];   // expected outputs for each upcoming cycle
  ent_t        cur;        // expected outputs for the current cycle
  logic [15:0] scr [0:4799];
  int          mrow, mcol;

  function automatic ent_t mk(input logic b, input logic w, input int ad, input logic [15:0] d);
    ent_t e;
    e.busy = b;
    e.we   = w;
    e.addr = ad[12:0];
    e.data = d;
    return e;
  endfunction

  task automatic push_clear();
    for (int i = 0; i < 4800; i++) begin
      scr[i] = BLANK;
      sched.push_back(mk(i != 4799, 1'b1, i, BLANK));
    end
  endtask

  task automatic model_accept(input logic [7:0] c, input logic [7:0] a);
    int          addr;
    int          nxt;
    bit          wr, inc, scroll;
    logic [15:0] wdat;
    wr = 0; inc = 0; scroll = 0;
    wdat = BLANK;
    addr = mrow * 80 + mcol;
    if (c == 8'h0C) begin
      mrow = 0;
      mcol = 0;
      sched.push_back(mk(1'b1, 1'b0, 0, 16'h0));
      push_clear();
      return;
    end
    if (c >= 8'h20 && c <= 8'h7E) begin
      wr = 1;
      wdat = {a, 1'b0, c[6:0]};
      if (mcol == 79) begin mcol = 0; inc = 1; end
      else mcol++;
    end else if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h0A) begin
      inc = 1;
    end else if (c == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        wr = 1;
        addr = mrow * 80 + mcol;
      end
`ifdef CONSOLE_TAB_EN
    end else if (c == 8'h09) begin
      nxt = (mcol / 8 + 1) * 8;
      if (nxt >= 80) begin mcol = 0; inc = 1; end
      else mcol = nxt;
`endif
    end
    if (inc) begin
      if (mrow == 59) scroll = 1;
      else mrow++;
    end
    if (wr) scr[addr] = wdat;
    if (!scroll) begin
      if (wr) sched.push_back(mk(1'b0, 1'b1, addr, wdat));
    end else begin
      sched.push_back(mk(1'b1, wr, addr, wdat));
      sched.push_back(mk(1'b1, 1'b0, 0, 16'h0));
      for (int k = 0; k < 4720; k++) sched.push_back(mk(1'b1, 1'b1, k, scr[k + 80]));
      for (int j = 0; j < 80; j++) sched.push_back(mk(j != 79, 1'b1, 4720 + j, BLANK));
      for (int k = 0; k < 4720; k++) scr[k] = scr[k + 80];
      for (int j = 4720; j < 4800; j++) scr[j] = BLANK;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched.delete();
      cur  = mk(1'b1, 1'b0, 0, 16'h0);
      mrow = 0;
      mcol = 0;
      push_clear();
    end else begin
      if (in_valid && !cur.busy) model_accept(in_char, in_attr);
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = mk(1'b0, 1'b0, 0, 16'h0);
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("in_ready", 32'(in_ready), 32'(!cur.busy));
    chk("cursor", 32'(cursor), 32'(mrow * 128 + mcol));
    chk("vram_we", 32'(vram_we), 32'(cur.we));
    chk("vram_ra_range", 32'(vram_ra < 13'd4800), 32'd1);
    if (cur.we) begin
      chk("vram_wa", 32'(vram_wa), 32'(cur.addr));
      chk("vram_wd", 32'(vram_wd), 32'(cur.data));
    end
    if (!rst) begin
      chk("rst_wa", 32'(vram_wa), 32'd0);
      chk("rst_wd", 32'(vram_wd), 32'd0);
      chk("rst_ra", 32'(vram_ra), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int n;
    in_char  = c;
    in_attr  = a;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 6000) chk("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 6000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, lfs;
    logic [15:0] old80, old4799, old320;
    logic [7:0]  c;
    int          r;

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Power-up clear.
    count_busy(n);
    chk("clear_cycles", 32'(n), 32'd4800);
    chk("clear_cursor", 32'(cursor), 32'h0);
    chk("clear_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 4800; i++) if (ram[i] !== BLANK) bad++;
    chk("clear_ram", 32'(bad), 32'd0);

    // First character.
    send(8'h41, 8'h0F);
    chk("A_we", 32'(vram_we), 32'd1);
    chk("A_wa", 32'(vram_wa), 32'd0);
    chk("A_wd", 32'(vram_wd), 32'h0F41);
    chk("A_cursor", 32'(cursor), 32'h0001);

    // Full row from (3,0), back to back.
    repeat (3) send(8'h0A, 8'h00);
    send(8'h0D, 8'h00);
    for (int i = 0; i < 80; i++) send(8'(8'h21 + i), 8'h07);
    chk("row_last_wa", 32'(vram_wa), 32'd319);
    chk("row_cursor", 32'(cursor), 32'd512);

    // Down to (59,5) and scroll with LF.
    repeat (55) send(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send(8'h78, 8'h1E);
    chk("pre_scroll_cursor", 32'(cursor), 32'd7557);
    @(posedge clk); #1;
    old80 = ram[80]; old4799 = ram[4799]; old320 = ram[320];
    send(8'h0A, 8'h00);
    count_busy(n);
    chk("scroll_cycles", 32'(n), 32'd4801);
    chk("scroll_cursor", 32'(cursor), 32'd7557);
    @(posedge clk); #1;
    chk("scroll_ram0", 32'(ram[0]), 32'(old80));
    chk("scroll_ram4719", 32'(ram[4719]), 32'(old4799));
    chk("scroll_ram240", 32'(ram[240]), 32'(old320));
    bad = 0;
    for (int i = 4720; i < 4800; i++) if (ram[i] !== BLANK) bad++;
    chk("scroll_fill", 32'(bad), 32'd0);

    // Form feed.
    send(8'h0C, 8'h00);
    chk("ff_cursor", 32'(cursor), 32'h0);
    count_busy(n);
    chk("ff_cycles", 32'(n), 32'd4800);

    // Backspace at col 0 and col 10 of row 2.
    send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    send(8'h08, 8'h00);
    chk("bs0_we", 32'(vram_we), 32'd0);
    chk("bs0_cursor", 32'(cursor), 32'd256);
    for (int i = 0; i < 10; i++) send(8'(8'h61 + i), 8'h02);
    send(8'h08, 8'h00);
    chk("bs_we", 32'(vram_we), 32'd1);
    chk("bs_wa", 32'(vram_wa), 32'd169);
    chk("bs_wd", 32'(vram_wd), 32'h0020);
    chk("bs_cursor", 32'(cursor), 32'd265);

    // Tab at col 3 and col 75.
    send(8'h0D, 8'h00);
    repeat (3) send(8'h2E, 8'h03);
    send(8'h09, 8'h00);
    chk("tab3_we", 32'(vram_we), 32'd0);
`ifdef CONSOLE_TAB_EN
    chk("tab3_cursor", 32'(cursor), 32'd264);
`else
    chk("tab3_cursor", 32'(cursor), 32'd259);
`endif
    send(8'h0D, 8'h00);
    repeat (75) send(8'h2D, 8'h04);
    send(8'h09, 8'h00);
    chk("tab75_we", 32'(vram_we), 32'd0);
`ifdef CONSOLE_TAB_EN
    chk("tab75_cursor", 32'(cursor), 32'd384);
`else
    chk("tab75_cursor", 32'(cursor), 32'd331);
`endif

    // Reset in the middle of a clear.
    send(8'h0C, 8'h00);
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_we", 32'(vram_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_cursor", 32'(cursor), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    count_busy(n);
    chk("midrst_clear_cycles", 32'(n), 32'd4800);

    // Random traffic near the bottom of the screen.
    repeat (57) send(8'h0A, 8'h00);
    lfs = 0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 72)      c = 8'($urandom_range(32, 126));
      else if (r < 75) begin
        if (lfs < 6) begin c = 8'h0A; lfs++; end
        else c = 8'h0D;
      end
      else if (r < 81) c = 8'h0D;
      else if (r < 87) c = 8'h08;
      else if (r < 91) c = 8'h09;
      else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h0C || c == 8'h0A) c = 8'h7F;
      end
      send(c, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    count_busy(n);
    chk("final_idle", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", total, errors);
    $finish;
  end

endmodule
